// File: rtl/unit_accumulator.sv
// Group accumulator behind unit_adder: sums {carry, sum} beats until in_last,
// then holds total, beat count and sticky overflow for a valid/ready handshake.
module unit_accumulator #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_p,
    input  logic [DATA_WIDTH-1:0] sum_in,
    input  logic                  carry_in,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic [CNT_WIDTH-1:0]  term_count,
    output logic                  overflow_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] operand;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 accept;

    assign in_ready     = !rst_p && (state_q != HOLD);
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state_q == HOLD);
    assign acc_out      = acc_q;
    assign term_count   = cnt_q;
    assign overflow_out = ovf_q;

    always_comb begin
        operand                 = '0;
        operand[DATA_WIDTH:0]   = {carry_in, sum_in};
        sum_full                = {1'b0, acc_q} + {1'b0, operand};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = operand;
                    cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_full[ACC_WIDTH-1:0];
                    if (sum_full[ACC_WIDTH]) ovf_d = 1'b1;
                    // Counter saturates; an attempted wrap is reported as overflow.
                    if (cnt_q == '1) ovf_d = 1'b1;
                    else             cnt_d = cnt_q + 1'b1;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_unit_accumulator.sv
// Directed bench for unit_accumulator: three instances (default, narrow
// accumulator, narrow counter) share one input stream.
module tb_unit_accumulator;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [3:0] sum_in;
    logic       carry_in;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic        d_in_ready, d_ovf, d_ov;
    logic [11:0] d_acc;
    logic [7:0]  d_cnt;
    logic        a_in_ready, a_ovf, a_ov;
    logic [5:0]  a_acc;
    logic [7:0]  a_cnt;
    logic        c_in_ready, c_ovf, c_ov;
    logic [11:0] c_acc;
    logic [1:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    unit_accumulator u_d0 (
        .clk(clk), .rst_p(rst_p), .sum_in(sum_in), .carry_in(carry_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(d_in_ready),
        .acc_out(d_acc), .term_count(d_cnt), .overflow_out(d_ovf),
        .out_valid(d_ov), .out_ready(out_ready)
    );

    unit_accumulator #(.ACC_WIDTH(6)) u_a6 (
        .clk(clk), .rst_p(rst_p), .sum_in(sum_in), .carry_in(carry_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
        .acc_out(a_acc), .term_count(a_cnt), .overflow_out(a_ovf),
        .out_valid(a_ov), .out_ready(out_ready)
    );

    unit_accumulator #(.CNT_WIDTH(2)) u_c2 (
        .clk(clk), .rst_p(rst_p), .sum_in(sum_in), .carry_in(carry_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(c_in_ready),
        .acc_out(c_acc), .term_count(c_cnt), .overflow_out(c_ovf),
        .out_valid(c_ov), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic c, input logic [3:0] s, input logic last);
        in_valid = 1'b1;
        carry_in = c;
        sum_in   = s;
        in_last  = last;
        tick();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        carry_in = 1'b0;
        sum_in   = 4'd0;
    endtask

    initial begin
        rst_p = 1'b1; out_ready = 1'b1;
        idle_in();
        tick();
        rst_p = 1'b0;
        #1;
        chk("rst_acc", 32'(d_acc), 0);
        chk("rst_cnt", 32'(d_cnt), 0);
        chk("rst_ovf", 32'(d_ovf), 0);
        chk("rst_ov", 32'(d_ov), 0);
        chk("rst_rdy", 32'(d_in_ready), 1);

        // in_last without in_valid must not start or end a group
        in_last = 1'b1;
        tick();
        chk("last_novalid_ov", 32'(d_ov), 0);
        chk("last_novalid_acc", 32'(d_acc), 0);
        in_last = 1'b0;

        // Basic group: 5 + 19 + 15 = 39
        beat(1'b0, 4'd5, 1'b0);
        beat(1'b1, 4'd3, 1'b0);
        chk("basic_mid_ov", 32'(d_ov), 0);
        beat(1'b0, 4'd15, 1'b1);
        idle_in();
        chk("basic_ov", 32'(d_ov), 1);
        chk("basic_acc", 32'(d_acc), 39);
        chk("basic_cnt", 32'(d_cnt), 3);
        chk("basic_ovf", 32'(d_ovf), 0);
        chk("basic_rdy_hold", 32'(d_in_ready), 0);
        tick();
        chk("basic_ov_drop", 32'(d_ov), 0);
        chk("basic_rdy_back", 32'(d_in_ready), 1);
        chk("basic_acc_kept", 32'(d_acc), 39);

        // Single-beat group: {1,15} = 31
        beat(1'b1, 4'd15, 1'b1);
        idle_in();
        chk("single_ov", 32'(d_ov), 1);
        chk("single_acc", 32'(d_acc), 31);
        chk("single_cnt", 32'(d_cnt), 1);
        tick();
        chk("single_ov_drop", 32'(d_ov), 0);

        // Backpressure: held result ignores incoming beats
        out_ready = 1'b0;
        beat(1'b0, 4'd1, 1'b1);
        in_valid = 1'b1; carry_in = 1'b0; sum_in = 4'd7; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", 32'(d_ov), 1);
            chk("bp_rdy", 32'(d_in_ready), 0);
            chk("bp_acc", 32'(d_acc), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_ov", 32'(d_ov), 0);
        chk("bp_hs_acc", 32'(d_acc), 1);
        tick();
        chk("bp_fresh_acc", 32'(d_acc), 7);
        chk("bp_fresh_cnt", 32'(d_cnt), 1);
        beat(1'b0, 4'd0, 1'b1);
        idle_in();
        chk("bp_end_acc", 32'(d_acc), 7);
        chk("bp_end_cnt", 32'(d_cnt), 2);
        tick();

        // Accumulator overflow: 3 x 31 = 93; 93 mod 64 = 29 in 6-bit instance
        beat(1'b1, 4'd15, 1'b0);
        beat(1'b1, 4'd15, 1'b0);
        beat(1'b1, 4'd15, 1'b1);
        idle_in();
        chk("aovf_acc", 32'(a_acc), 29);
        chk("aovf_ovf", 32'(a_ovf), 1);
        chk("aovf_cnt", 32'(a_cnt), 3);
        chk("aovf_wide_acc", 32'(d_acc), 93);
        chk("aovf_wide_ovf", 32'(d_ovf), 0);
        tick();
        beat(1'b0, 4'd2, 1'b0);
        idle_in();
        chk("aovf_clear_ovf", 32'(a_ovf), 0);
        chk("aovf_clear_acc", 32'(a_acc), 2);
        beat(1'b0, 4'd0, 1'b1);
        idle_in();
        tick();

        // Counter saturation: five beats of 1 with a 2-bit counter
        for (int i = 0; i < 5; i++) beat(1'b0, 4'd1, (i == 4));
        idle_in();
        chk("csat_cnt", 32'(c_cnt), 3);
        chk("csat_acc", 32'(c_acc), 5);
        chk("csat_ovf", 32'(c_ovf), 1);
        chk("csat_wide_cnt", 32'(d_cnt), 5);
        chk("csat_wide_ovf", 32'(d_ovf), 0);
        tick();

        // Reset mid-group aborts without emitting a result
        beat(1'b0, 4'd3, 1'b0);
        beat(1'b0, 4'd4, 1'b0);
        idle_in();
        rst_p = 1'b1;
        #1;
        chk("mrst_rdy_low", 32'(d_in_ready), 0);
        tick();
        rst_p = 1'b0;
        #1;
        chk("mrst_acc", 32'(d_acc), 0);
        chk("mrst_cnt", 32'(d_cnt), 0);
        chk("mrst_ov", 32'(d_ov), 0);
        chk("mrst_rdy", 32'(d_in_ready), 1);
        beat(1'b0, 4'd2, 1'b0);
        beat(1'b0, 4'd4, 1'b1);
        idle_in();
        chk("mrst_new_ov", 32'(d_ov), 1);
        chk("mrst_new_acc", 32'(d_acc), 6);
        chk("mrst_new_cnt", 32'(d_cnt), 2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unit_accumulator.md
Name: unit_accumulator

Overview:
- Downstream stage of unit_adder in the matrix-multiply datapath.
- Consumes the adder's {carry_out, sum_out} results as a stream of beats and accumulates one group of partial sums into a wide running total.
- A group is one dot-product term set, delimited by in_last.
- Presents the finished total, the beat count and an overflow flag through a valid/ready handshake to the result writer.

Parameters:
- DATA_WIDTH, 4, width of sum_in; must match unit_adder DATA_WIDTH.
- ACC_WIDTH, 12, accumulator width; must be >= DATA_WIDTH+1.
- CNT_WIDTH, 8, width of the beat counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_p  input  1  synchronous reset, active-high.
- sum_in  input  DATA_WIDTH  partial sum from unit_adder.
- carry_in  input  1  carry from unit_adder; forms operand MSB.
- in_valid  input  1  beat present on sum_in/carry_in/in_last.
- in_last  input  1  final beat of the current group.
- in_ready  output  1  block can accept a beat this cycle.
- acc_out  output  ACC_WIDTH  accumulated total.
- term_count  output  CNT_WIDTH  number of beats in the group.
- overflow_out  output  1  sticky flag: accumulator or counter overflowed during the group.
- out_valid  output  1  result fields hold a complete group.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Operand = {carry_in, sum_in}, zero-extended to ACC_WIDTH.
- Accept condition: in_valid && in_ready. Result handshake: out_valid && out_ready.
- in_ready = !rst_p && (state != HOLD). This is combinational from state and rst_p.
- Reset (rst_p high at an edge) forces: state=IDLE, acc_out=0, term_count=0, overflow_out=0, out_valid=0. Reset aborts any group in progress; no partial result is emitted.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE on accept:
  - acc_out <= operand; term_count <= 1; overflow_out <= 0.
  - Next state is HOLD if in_last, else ACCUM.
  - A first beat discards the previous group's values.
- ACCUM on accept:
  - acc_out <= (acc_out + operand) mod 2^ACC_WIDTH.
  - If the true sum is >= 2^ACC_WIDTH, overflow_out <= 1.
  - term_count increments and saturates at 2^CNT_WIDTH-1; an increment attempted at saturation sets overflow_out <= 1.
  - Next state is HOLD if in_last, else stays ACCUM.
- ACCUM with no accept: all registers hold.
- HOLD:
  - out_valid = 1; acc_out, term_count and overflow_out are stable.
  - in_valid is ignored because in_ready = 0.
  - On result handshake: next state IDLE; out_valid drops on the next cycle; acc_out, term_count and overflow_out keep their values until the next first beat.
- Latency: last beat accepted at edge N gives out_valid high in the cycle after edge N. Total latency is 1 cycle; there is no combinational input-to-output path except in_ready.
- Single-beat group (in_last on first beat): acc_out = operand, term_count = 1.
- Throughput: at most 1 beat per cycle, plus 1 bubble cycle per group for the result handshake.
- out_valid never deasserts without a handshake, except on reset.
- in_last with in_valid low has no effect.

Test Plan:
- Basic group (DATA_WIDTH=4, ACC_WIDTH=12): beats {0,5}, {1,3}, {0,15}+last on consecutive cycles, out_ready=1 → out_valid high 1 cycle after the last beat, acc_out=39, term_count=3, overflow_out=0; in_ready returns high the following cycle.
- Single beat: {1,15}+last → acc_out=31, term_count=1, out_valid for exactly 1 cycle with out_ready=1.
- Backpressure: complete a group with out_ready=0 for 5 cycles while driving in_valid=1 with {0,7} → out_valid stays 1, in_ready=0, acc_out unchanged. Raise out_ready → handshake, then the next accepted beat starts a fresh group with acc_out=7.
- Accumulator overflow (ACC_WIDTH=6): beats 31, 31, 31+last → acc_out=29 (93 mod 64), overflow_out=1, term_count=3. The next group's first beat clears overflow_out.
- Counter saturation (CNT_WIDTH=2): five beats of {0,1}, last on the 5th → term_count=3, acc_out=5, overflow_out=1.
- Reset mid-group: two beats accepted, then rst_p=1 for 1 cycle → next cycle state IDLE, acc_out=0, term_count=0, out_valid=0, in_ready=1. A new group 2, 4+last → acc_out=6, term_count=2.
